// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types for the program-counter unit. Holds the
//                next-PC operation encoding and the width of the pc_op port.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Width of the pc_op port.
    localparam int PC_OP_W = 2;

    // Next-PC operation selected by pc_op.
    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_INC = 2'b00,  // sequential: pc_out + STEP
        PC_OP_BR  = 2'b01,  // relative:   pc_out + signed offset
        PC_OP_JMP = 2'b10,  // absolute:   target
        PC_OP_RET = 2'b11   // return:     top of return-address stack
    } pc_op_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras
//  Description : Return-address stack. LIFO of DEPTH entries, each WIDTH bits.
//                A push while full and a pop while empty are ignored here;
//                the parent decides whether that is an error.
//  Ports       : clk          rising-edge clock
//                rst          asynchronous active-high reset (empties stack)
//                i_push       push i_push_data onto the stack
//                i_pop        remove the top entry
//                i_push_data  value written on push
//                o_top        current top entry (undefined while empty)
//                o_full       stack holds DEPTH entries
//                o_empty      stack holds no entries
//  Revision    : 1.0  initial release
// ============================================================================
module pc_ras #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    // The entry count doubles as the write slot; the top is one below it.
    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_rd_idx  = w_wr_idx - PTR_W'(1);

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[w_rd_idx];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage is not reset: an entry is only ever read after being pushed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter unit at the head of the fetch path.
//                Computes the next PC (increment, relative branch, absolute
//                jump, return) and registers it when enabled. With the
//                PC_RAS_EN macro defined, a return-address stack supports
//                call (BR/JMP + pc_push) and return (RET).
//  Ports       : clock      rising-edge clock
//                reset      asynchronous active-high reset
//                pc_en      1 = update PC, 0 = stall (all state holds)
//                pc_op      00 INC, 01 BR, 10 JMP, 11 RET
//                pc_push    with BR/JMP: push pc_out+STEP (call)
//                pc_target  absolute JMP target
//                pc_offset  signed BR offset relative to pc_out
//                pc_out     registered current PC
//                pc_next    value pc_out takes at the next enabled edge
//                ras_full   stack holds RAS_DEPTH entries
//                ras_empty  stack holds no entries
//                ras_err    sticky stack overflow/underflow flag
//  Config      : PC_RAS_EN  defined = return-address stack present
//  Revision    : 1.0  initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int STEP         = 1,
    parameter int RESET_VECTOR = 0,
    parameter int RAS_DEPTH    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pc_en,
    input  logic [PC_OP_W-1:0] pc_op,
    input  logic               pc_push,
    input  logic [WIDTH-1:0]   pc_target,
    input  logic [WIDTH-1:0]   pc_offset,
    output logic [WIDTH-1:0]   pc_out,
    output logic [WIDTH-1:0]   pc_next,
    output logic               ras_full,
    output logic               ras_empty,
    output logic               ras_err
);

    localparam logic [WIDTH-1:0] c_step         = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_reset_vector = WIDTH'(RESET_VECTOR);

    pc_op_e           w_op;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_br;
    logic [WIDTH-1:0] w_ret_target;

    assign w_op     = pc_op_e'(pc_op);
    assign w_pc_inc = pc_out + c_step;
    // Two's-complement offset: plain modular addition covers negative values.
    assign w_pc_br  = pc_out + pc_offset;

`ifdef PC_RAS_EN
    logic             w_push_req;
    logic             w_pop_req;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_full;
    logic             w_ras_empty;
    logic             r_ras_err;

    // Calls are BR/JMP with pc_push; pc_push on INC/RET is ignored.
    assign w_push_req = pc_en && pc_push && ((w_op == PC_OP_BR) || (w_op == PC_OP_JMP));
    assign w_pop_req  = pc_en && (w_op == PC_OP_RET);

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clock),
        .rst         (reset),
        .i_push      (w_push_req),
        .i_pop       (w_pop_req),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    // Underflowing return falls through to the sequential address.
    assign w_ret_target = w_ras_empty ? w_pc_inc : w_ras_top;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ras_err <= 1'b0;
        end else if ((w_push_req && w_ras_full) || (w_pop_req && w_ras_empty)) begin
            r_ras_err <= 1'b1;
        end
    end

    assign ras_full  = w_ras_full;
    assign ras_empty = w_ras_empty;
    assign ras_err   = r_ras_err;
`else
    // No stack: RET degenerates to INC, call requests are ignored.
    logic w_unused_push;
    localparam int c_unused_ras_depth = RAS_DEPTH;

    assign w_unused_push = pc_push;
    assign w_ret_target  = w_pc_inc;
    assign ras_full      = 1'b0;
    assign ras_empty     = 1'b1;
    assign ras_err       = 1'b0;
`endif

    always_comb begin
        pc_next = w_pc_inc;
        case (w_op)
            PC_OP_INC: pc_next = w_pc_inc;
            PC_OP_BR:  pc_next = w_pc_br;
            PC_OP_JMP: pc_next = pc_target;
            PC_OP_RET: pc_next = w_ret_target;
            default:   pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out <= c_reset_vector;
        end else if (pc_en) begin
            pc_out <= pc_next;
        end
    end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit (WIDTH=8, STEP=1,
//                RESET_VECTOR=0, RAS_DEPTH=4). Expectations follow the
//                PC_RAS_EN setting of the build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pc_en = 1'b0;
    logic [1:0]       pc_op = 2'b00;
    logic             pc_push = 1'b0;
    logic [WIDTH-1:0] pc_target = '0;
    logic [WIDTH-1:0] pc_offset = '0;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;

    int total = 0;
    int bad   = 0;

    // Reference state: PC value, return stack as a queue, sticky error.
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_ras[$];
    bit               m_err;

    always #5 clock = ~clock;

    pc_unit #(
        .WIDTH        (WIDTH),
        .STEP         (1),
        .RESET_VECTOR (0),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pc_en     (pc_en),
        .pc_op     (pc_op),
        .pc_push   (pc_push),
        .pc_target (pc_target),
        .pc_offset (pc_offset),
        .pc_out    (pc_out),
        .pc_next   (pc_next),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    function automatic logic [WIDTH-1:0] model_next();
        logic [WIDTH-1:0] v;
        case (pc_op)
            2'd0: v = m_pc + 8'd1;
            2'd1: v = m_pc + pc_offset;
            2'd2: v = pc_target;
            default: v = (RAS_EN && m_ras.size() > 0) ? m_ras[$] : m_pc + 8'd1;
        endcase
        return v;
    endfunction

    function automatic bit exp_empty();
        return RAS_EN ? (m_ras.size() == 0) : 1'b1;
    endfunction

    function automatic bit exp_full();
        return RAS_EN ? (m_ras.size() == DEPTH) : 1'b0;
    endfunction

    task automatic drive(input bit en, input logic [1:0] op, input bit push,
                         input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] off);
        pc_en     = en;
        pc_op     = op;
        pc_push   = push;
        pc_target = tgt;
        pc_offset = off;
        #1;
    endtask

    // Advance one clock, updating the reference from the driven inputs.
    task automatic tick();
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] ret_addr;
        nxt      = model_next();
        ret_addr = m_pc + 8'd1;
        if (pc_en) begin
            if (RAS_EN && pc_push && (pc_op == 2'd1 || pc_op == 2'd2)) begin
                if (m_ras.size() == DEPTH) m_err = 1'b1;
                else m_ras.push_back(ret_addr);
            end
            if (RAS_EN && pc_op == 2'd3) begin
                if (m_ras.size() == 0) m_err = 1'b1;
                else void'(m_ras.pop_back());
            end
            m_pc = nxt;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_pc  = 8'h00;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (pc_out !== 8'h00 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pc_out=%h empty=%b full=%b err=%b, want 00 1 0 0",
                     pc_out, ras_empty, ras_full, ras_err);
        end
        drive(1'b1, 2'd2, 1'b0, 8'h23, 8'h00);
        tick();
        total++;
        if (pc_out !== 8'h23) begin
            bad++;
            $display("FAIL reset_pre_jmp: pc_out=%h want 23", pc_out);
        end
        // Assert reset between edges; it must act without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (pc_out !== 8'h00 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: pc_out=%h empty=%b err=%b, want 00 1 0",
                     pc_out, ras_empty, ras_err);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_pc  = 8'h00;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'd2, 1'b0, 8'hFF, 8'h00);
        tick();
        drive(1'b1, 2'd0, 1'b0, 8'h00, 8'h00);
        total++;
        if (pc_next !== 8'h00) begin
            bad++;
            $display("FAIL wrap_next: pc_next=%h want 00", pc_next);
        end
        tick();
        total++;
        if (pc_out !== 8'h00) begin
            bad++;
            $display("FAIL wrap_out: pc_out=%h want 00", pc_out);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 2'd2, 1'b0, 8'h05, 8'h00);
        tick();
        drive(1'b0, 2'd2, 1'b1, 8'h40, 8'h00);
        total++;
        if (pc_next !== 8'h40) begin
            bad++;
            $display("FAIL stall_next: pc_next=%h want 40", pc_next);
        end
        tick();
        tick();
        total++;
        if (pc_out !== 8'h05 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: pc_out=%h empty=%b err=%b, want 05 1 0",
                     pc_out, ras_empty, ras_err);
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 2'd2, 1'b0, 8'h10, 8'h00);
        tick();
        drive(1'b1, 2'd1, 1'b0, 8'h00, 8'hFC);
        tick();
        total++;
        if (pc_out !== 8'h0C) begin
            bad++;
            $display("FAIL branch_back: pc_out=%h want 0c", pc_out);
        end
        drive(1'b1, 2'd2, 1'b0, 8'hF0, 8'h00);
        tick();
        drive(1'b1, 2'd1, 1'b0, 8'h00, 8'h7F);
        total++;
        if (pc_next !== 8'h6F) begin
            bad++;
            $display("FAIL branch_fwd_next: pc_next=%h want 6f", pc_next);
        end
        tick();
        total++;
        if (pc_out !== 8'h6F) begin
            bad++;
            $display("FAIL branch_fwd: pc_out=%h want 6f", pc_out);
        end
    endtask

    task automatic test_call_ret();
        drive(1'b1, 2'd2, 1'b0, 8'h05, 8'h00);
        tick();
        drive(1'b1, 2'd2, 1'b1, 8'h80, 8'h00);
        tick();
        total++;
        if (pc_out !== 8'h80 || ras_empty !== !RAS_EN) begin
            bad++;
            $display("FAIL call: pc_out=%h empty=%b, want 80 %b", pc_out, ras_empty, !RAS_EN);
        end
        drive(1'b1, 2'd3, 1'b0, 8'h00, 8'h00);
        tick();
        total++;
        if (pc_out !== (RAS_EN ? 8'h06 : 8'h81) || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL ret: pc_out=%h empty=%b err=%b, want %h 1 0",
                     pc_out, ras_empty, ras_err, RAS_EN ? 8'h06 : 8'h81);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
            total++;
            if (pc_next !== model_next()) begin
                bad++;
                $display("FAIL rand_next[%0d]: pc_next=%h want %h", i, pc_next, model_next());
            end
            tick();
            total++;
            if (pc_out !== m_pc || ras_empty !== exp_empty() || ras_full !== exp_full()
                || ras_err !== m_err) begin
                bad++;
                $display("FAIL rand_state[%0d]: pc=%h e=%b f=%b err=%b, want %h %b %b %b",
                         i, pc_out, ras_empty, ras_full, ras_err, m_pc, exp_empty(), exp_full(), m_err);
            end
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] rets[4];
        logic [WIDTH-1:0] pc_before;
        apply_reset();
        drive(1'b1, 2'd2, 1'b0, 8'h10, 8'h00);
        tick();
        for (int i = 0; i < 5; i++) begin
            pc_before = pc_out;
            if (i < 4) rets[i] = pc_before + 8'd1;
            drive(1'b1, 2'd2, 1'b1, 8'(8'h20 + 16 * i), 8'h00);
            tick();
            total++;
            if (pc_out !== 8'(8'h20 + 16 * i) || ras_full !== (RAS_EN && i >= 3)
                || ras_err !== (RAS_EN && i == 4)) begin
                bad++;
                $display("FAIL push[%0d]: pc=%h full=%b err=%b, want %h %b %b", i, pc_out,
                         ras_full, ras_err, 8'(8'h20 + 16 * i), RAS_EN && i >= 3, RAS_EN && i == 4);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            pc_before = pc_out;
            drive(1'b1, 2'd3, 1'b0, 8'h00, 8'h00);
            tick();
            total++;
            if (pc_out !== (RAS_EN ? rets[i] : pc_before + 8'd1)) begin
                bad++;
                $display("FAIL pop[%0d]: pc=%h want %h", i, pc_out,
                         RAS_EN ? rets[i] : pc_before + 8'd1);
            end
        end
        total++;
        if (ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL pop_empty: empty=%b want 1", ras_empty);
        end
        pc_before = pc_out;
        drive(1'b1, 2'd3, 1'b0, 8'h00, 8'h00);
        total++;
        if (pc_next !== pc_before + 8'd1) begin
            bad++;
            $display("FAIL underflow_next: pc_next=%h want %h", pc_next, pc_before + 8'd1);
        end
        tick();
        total++;
        if (pc_out !== pc_before + 8'd1 || ras_err !== RAS_EN || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL underflow: pc=%h err=%b empty=%b, want %h %b 1",
                     pc_out, ras_err, ras_empty, pc_before + 8'd1, RAS_EN);
        end
    endtask

    initial begin
        m_pc  = 8'h00;
        m_err = 1'b0;
        test_reset();
        test_wrap();
        test_stall();
        test_branch();
        test_call_ret();
        test_random();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
